// File: rtl/gmii_tx_arb.sv
// gmii_tx_arb: frame-atomic N-channel arbiter for the byte-wide GMII transmit path.
// A channel is granted in IDLE, holds the grant for one whole frame, and the
// arbiter then enforces an inter-frame gap before the next arbitration.
module gmii_tx_arb #(
    parameter int N_CH          = 2,
    parameter int DATA_W        = 8,
    parameter int ARB_MODE      = 0,
    parameter int IFG_CYCLES    = 12,
    parameter int GRANT_TIMEOUT = 16,
    localparam int OW = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    input  logic [N_CH-1:0]        ch_req,
    output logic [N_CH-1:0]        ch_grant,
    input  logic [N_CH-1:0]        ch_txen,
    input  logic [N_CH*DATA_W-1:0] ch_txdata,
    input  logic                   gmii_txbusy,
    output logic                   gmii_txen,
    output logic [DATA_W-1:0]      gmii_txdata,
    output logic [OW-1:0]          arb_owner,
    output logic                   arb_busy,
    output logic                   err_timeout
);

    localparam int TW = $clog2(GRANT_TIMEOUT + 1);
    localparam int IW = $clog2(IFG_CYCLES + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] SEND  = 2'd2;
    localparam logic [1:0] IFG   = 2'd3;

    logic [1:0]        state;
    logic [OW-1:0]     rr_ptr;
    logic [TW-1:0]     tmo_cnt;
    logic [IW-1:0]     ifg_cnt;
    logic [OW-1:0]     winner;
    logic [N_CH-1:0]   winner_oh;
    logic              own_txen;
    logic [DATA_W-1:0] own_data;
    logic              vld_p0;
    logic [DATA_W-1:0] data_p0;
    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;

    // Fixed priority takes the lowest requester; round robin starts the search
    // just above the last owner, so the last owner is considered last.
    function automatic logic [OW-1:0] pick_winner(input logic [N_CH-1:0] req,
                                                  input logic [OW-1:0]   ptr);
        logic [OW-1:0] win;
        logic          found;
        int            idx;
        win   = '0;
        found = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            if (ARB_MODE == 0) idx = i - 1;
            else               idx = (int'(ptr) + i) % N_CH;
            if (!found && req[idx]) begin
                win   = OW'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign winner   = pick_winner(ch_req, rr_ptr);
    assign arb_busy = (state != IDLE);

    // One-hot form of the arbitration winner
    always_comb begin
        winner_oh = '0;
        for (int k = 0; k < N_CH; k++) begin
            winner_oh[k] = (int'(winner) == k);
        end
    end

    // Select the current owner's enable and data
    always_comb begin
        own_txen = 1'b0;
        own_data = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (int'(arb_owner) == k) begin
                own_txen = ch_txen[k];
                own_data = ch_txdata[k*DATA_W +: DATA_W];
            end
        end
    end

    // Stage p0: only the owner's bytes pass, and only while it holds the grant
    assign vld_p0  = own_txen && ((state == GRANT) || (state == SEND));
    assign data_p0 = vld_p0 ? own_data : '0;

    // Arbitration FSM: grant, frame tracking, grant timeout and inter-frame gap
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= IDLE;
            ch_grant    <= '0;
            arb_owner   <= '0;
            rr_ptr      <= OW'(N_CH - 1);
            tmo_cnt     <= '0;
            ifg_cnt     <= '0;
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if ((|ch_req) && !gmii_txbusy) begin
                        ch_grant  <= winner_oh;
                        arb_owner <= winner;
                        rr_ptr    <= winner;
                        tmo_cnt   <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (own_txen) begin
                        state <= SEND;
                    end else if (tmo_cnt == TW'(GRANT_TIMEOUT - 1)) begin
                        ch_grant    <= '0;
                        err_timeout <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                SEND: begin
                    if (!own_txen) begin
                        ch_grant <= '0;
                        ifg_cnt  <= '0;
                        state    <= IFG;
                    end
                end
                IFG: begin
                    if (!gmii_txbusy) begin
                        if (ifg_cnt == IW'(IFG_CYCLES - 1)) state <= IDLE;
                        else                                ifg_cnt <= ifg_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage p1: registered output byte, cleared on reset so a frame is cut short
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else begin
            vld_p1  <= vld_p0;
            data_p1 <= data_p0;
        end
    end

    assign gmii_txen   = vld_p1;
    assign gmii_txdata = data_p1;

endmodule

// File: tb/tb_gmii_tx_arb.sv
// Bench for gmii_tx_arb: a fixed-priority 2-channel instance and a round-robin
// 4-channel instance, exercised one at a time against a frame-level model.
module tb_gmii_tx_arb;

    localparam int FP_N = 2, FP_IFG = 12, FP_TMO = 16;
    localparam int RR_N = 4, RR_IFG = 5,  RR_TMO = 6;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        cfg;           // 0: fixed-priority instance active, 1: round-robin instance
    logic [3:0]  req;
    logic [3:0]  txen;
    logic [31:0] txdata;
    logic        txbusy;

    logic [1:0]  fp_grant;
    logic        fp_txen;
    logic [7:0]  fp_txdata;
    logic [0:0]  fp_owner;
    logic        fp_busy, fp_err;

    logic [3:0]  rr_grant;
    logic        rr_txen;
    logic [7:0]  rr_txdata;
    logic [1:0]  rr_owner;
    logic        rr_busy, rr_err;

    logic [3:0]  o_grant;
    logic        o_txen;
    logic [7:0]  o_data;
    logic [1:0]  o_owner;
    logic        o_busy, o_err;

    int n_vec, n_err, cyc;
    int exp_owner, rr_last;
    int last_tx, prev_ifg_busy;
    bit have_last;

    always #5 sys_clk = ~sys_clk;

    gmii_tx_arb #(.N_CH(FP_N), .DATA_W(8), .ARB_MODE(0),
                  .IFG_CYCLES(FP_IFG), .GRANT_TIMEOUT(FP_TMO)) dut_fp (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .ch_req     (cfg ? 2'b00 : req[1:0]),
        .ch_grant   (fp_grant),
        .ch_txen    (cfg ? 2'b00 : txen[1:0]),
        .ch_txdata  (cfg ? 16'h0000 : txdata[15:0]),
        .gmii_txbusy(txbusy),
        .gmii_txen  (fp_txen),
        .gmii_txdata(fp_txdata),
        .arb_owner  (fp_owner),
        .arb_busy   (fp_busy),
        .err_timeout(fp_err)
    );

    gmii_tx_arb #(.N_CH(RR_N), .DATA_W(8), .ARB_MODE(1),
                  .IFG_CYCLES(RR_IFG), .GRANT_TIMEOUT(RR_TMO)) dut_rr (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .ch_req     (cfg ? req : 4'h0),
        .ch_grant   (rr_grant),
        .ch_txen    (cfg ? txen : 4'h0),
        .ch_txdata  (cfg ? txdata : 32'h0),
        .gmii_txbusy(txbusy),
        .gmii_txen  (rr_txen),
        .gmii_txdata(rr_txdata),
        .arb_owner  (rr_owner),
        .arb_busy   (rr_busy),
        .err_timeout(rr_err)
    );

    always_comb begin
        if (cfg) begin
            o_grant = rr_grant;
            o_txen  = rr_txen;
            o_data  = rr_txdata;
            o_owner = rr_owner;
            o_busy  = rr_busy;
            o_err   = rr_err;
        end else begin
            o_grant = {2'b00, fp_grant};
            o_txen  = fp_txen;
            o_data  = fp_txdata;
            o_owner = {1'b0, fp_owner};
            o_busy  = fp_busy;
            o_err   = fp_err;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_outs(input string tag, input logic [3:0] g, input logic tx,
                               input logic [7:0] d, input logic b, input logic e);
        check_eq({tag, "_grant"}, 32'(o_grant), 32'(g));
        check_eq({tag, "_txen"},  32'(o_txen),  32'(tx));
        check_eq({tag, "_data"},  32'(o_data),  32'(d));
        check_eq({tag, "_busy"},  32'(o_busy),  32'(b));
        check_eq({tag, "_err"},   32'(o_err),   32'(e));
        check_eq({tag, "_owner"}, 32'(o_owner), 32'(exp_owner));
    endtask

    task automatic tick;
        @(posedge sys_clk);
        #1;
        cyc++;
    endtask

    // Random enables and data on every channel except the owner
    task automatic junk(input int n, input int w);
        for (int k = 0; k < n; k++) begin
            if (k != w) begin
                txen[k]          = 1'($urandom);
                txdata[k*8 +: 8] = 8'($urandom);
            end
        end
    endtask

    // Which channel wins given the request set and the previous owner
    function automatic int model_winner(input logic [3:0] r, input int n, input int mode,
                                        input int last);
        int c;
        if (mode == 0) begin
            for (int i = 0; i < n; i++) if (r[i]) return i;
            return -1;
        end
        c = last;
        for (int s = 0; s < n; s++) begin
            c = (c + 1) % n;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    // One arbitration, then either a frame plus gap or a grant timeout.
    // Entered and left in an IDLE cycle, just after a clock edge.
    task automatic run_round(input int n, input int mode, input int ifg, input int tmo,
                             input logic [3:0] req_set, input int d_set, input int len_set,
                             input logic [7:0] base);
        logic [3:0] mask, r, g;
        logic [7:0] b;
        int nb, w, d, len, cnt, nbusy, guard;
        mask = 4'((1 << n) - 1);

        nb = (req_set != 4'h0) ? 0 : int'($urandom_range(0, 2));
        txbusy = (nb > 0);
        for (int k = 0; k < nb; k++) begin
            req = 4'($urandom) & mask;
            tick;
            expect_outs("idle_busy", 4'h0, 1'b0, 8'h00, 1'b0, 1'b0);
            if (k == nb - 1) txbusy = 1'b0;
        end

        if (req_set != 4'h0) r = req_set & mask;
        else begin
            r = 4'($urandom) & mask;
            if (r == 4'h0) r = 4'h1 << $urandom_range(0, n - 1);
        end
        req = r;
        w = model_winner(r, n, mode, rr_last);
        tick;
        exp_owner = w;
        rr_last   = w;
        g = 4'(1 << w);
        expect_outs("grant", g, 1'b0, 8'h00, 1'b1, 1'b0);

        if (d_set >= 0)              d = d_set;
        else if ($urandom % 5 == 0)  d = tmo;
        else                         d = int'($urandom_range(0, tmo - 1));

        if (d >= tmo) begin
            for (int k = 0; k < tmo; k++) begin
                junk(n, w);
                txen[w] = 1'b0;
                req = 4'($urandom) & mask;
                tick;
                if (k < tmo - 1) expect_outs("grant_wait", g, 1'b0, 8'h00, 1'b1, 1'b0);
                else             expect_outs("timeout", 4'h0, 1'b0, 8'h00, 1'b0, 1'b1);
            end
            txen = 4'h0;
            req  = 4'h0;
            tick;
            expect_outs("timeout_end", 4'h0, 1'b0, 8'h00, 1'b0, 1'b0);
            have_last = 1'b0;
            return;
        end

        for (int k = 0; k < d; k++) begin
            junk(n, w);
            txen[w] = 1'b0;
            req = 4'($urandom) & mask;
            tick;
            expect_outs("grant_wait", g, 1'b0, 8'h00, 1'b1, 1'b0);
        end

        len = (len_set > 0) ? len_set : int'($urandom_range(1, 5));
        for (int j = 0; j < len; j++) begin
            b = (base != 8'h00) ? 8'(base + 8'(j) + 8'h01) : 8'($urandom);
            junk(n, w);
            txen[w] = 1'b1;
            txdata[w*8 +: 8] = b;
            req = 4'($urandom) & mask;
            tick;
            if (j == 0 && have_last)
                check_eq("frame_gap", 32'(cyc - last_tx), 32'(ifg + prev_ifg_busy + 3 + nb + d));
            expect_outs("send", g, 1'b1, b, 1'b1, 1'b0);
        end
        last_tx = cyc;

        junk(n, w);
        txen[w] = 1'b0;
        txdata[w*8 +: 8] = 8'($urandom);
        req = 4'($urandom) & mask;
        tick;
        expect_outs("frame_end", 4'h0, 1'b0, 8'h00, 1'b1, 1'b0);

        cnt = 0;
        nbusy = 0;
        guard = 0;
        while (cnt < ifg) begin
            txbusy = (guard < 3 * ifg) && ($urandom % 4 == 0);
            txen   = 4'($urandom) & mask;
            txdata = 32'($urandom);
            req    = 4'($urandom) & mask;
            if (txbusy) nbusy++;
            else        cnt++;
            guard++;
            tick;
            if (cnt < ifg) expect_outs("ifg", 4'h0, 1'b0, 8'h00, 1'b1, 1'b0);
            else           expect_outs("ifg_done", 4'h0, 1'b0, 8'h00, 1'b0, 1'b0);
        end
        txbusy = 1'b0;
        txen   = 4'h0;
        req    = 4'h0;
        prev_ifg_busy = nbusy;
        have_last = 1'b1;
    endtask

    // Reset pulse in the middle of a frame on the round-robin instance
    task automatic reset_mid_frame(input int n);
        logic [3:0] mask, g;
        int w;
        mask = 4'((1 << n) - 1);
        req = mask;
        w = model_winner(mask, n, 1, rr_last);
        tick;
        exp_owner = w;
        rr_last   = w;
        g = 4'(1 << w);
        expect_outs("rst_grant", g, 1'b0, 8'h00, 1'b1, 1'b0);
        txen[w] = 1'b1;
        txdata[w*8 +: 8] = 8'h5A;
        tick;
        expect_outs("rst_send", g, 1'b1, 8'h5A, 1'b1, 1'b0);
        #2;
        sys_rst = 1'b1;
        #1;
        exp_owner = 0;
        expect_outs("rst_async", 4'h0, 1'b0, 8'h00, 1'b0, 1'b0);
        txen = 4'h0;
        req  = 4'h0;
        tick;
        sys_rst = 1'b0;
        expect_outs("rst_hold", 4'h0, 1'b0, 8'h00, 1'b0, 1'b0);
        rr_last   = n - 1;
        have_last = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        cfg = 1'b0; sys_rst = 1'b1;
        req = 4'h0; txen = 4'h0; txdata = 32'h0; txbusy = 1'b0;
        exp_owner = 0; rr_last = FP_N - 1;
        last_tx = 0; prev_ifg_busy = 0; have_last = 1'b0;

        #12;
        expect_outs("reset", 4'h0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_eq("rr_reset_grant", 32'(rr_grant), 32'h0);
        check_eq("rr_reset_busy",  32'(rr_busy),  32'h0);
        check_eq("rr_reset_txen",  32'(rr_txen),  32'h0);
        tick;
        sys_rst = 1'b0;

        // Fixed priority: simultaneous requests, timeout, one-byte frame, random traffic
        run_round(FP_N, 0, FP_IFG, FP_TMO, 4'b0011, 0, 4, 8'hA0);
        run_round(FP_N, 0, FP_IFG, FP_TMO, 4'b0010, 0, 4, 8'hB0);
        run_round(FP_N, 0, FP_IFG, FP_TMO, 4'b0010, FP_TMO, 0, 8'h00);
        run_round(FP_N, 0, FP_IFG, FP_TMO, 4'b0011, 0, 1, 8'h54);
        for (int i = 0; i < 20; i++)
            run_round(FP_N, 0, FP_IFG, FP_TMO, 4'h0, -1, 0, 8'h00);

        // Round robin: full rotation, then random traffic, then reset mid-frame
        cfg = 1'b1;
        exp_owner = 0;
        rr_last = RR_N - 1;
        have_last = 1'b0;
        for (int i = 0; i < 5; i++)
            run_round(RR_N, 1, RR_IFG, RR_TMO, 4'hF, 0, 2, 8'h00);
        for (int i = 0; i < 30; i++)
            run_round(RR_N, 1, RR_IFG, RR_TMO, 4'h0, -1, 0, 8'h00);
        reset_mid_frame(RR_N);
        run_round(RR_N, 1, RR_IFG, RR_TMO, 4'hF, 0, 2, 8'h10);
        check_eq("rr_after_reset_owner", 32'(o_owner), 32'h0);
        for (int i = 0; i < 10; i++)
            run_round(RR_N, 1, RR_IFG, RR_TMO, 4'h0, -1, 0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
